// File: rtl/divide_arbiter.sv
// Round-robin sequencer that shares one combinational divider among NREQ requesters,
// holding the divider operands for SETTLE cycles before capturing the result.
module divide_arbiter #(
    parameter int SIZE   = 16,
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int SETTLE = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*SIZE-1:0]   req_dividend,
    input  logic [NREQ*SIZE-1:0]   req_divisor,
    output logic [SIZE-1:0]        div_dividend,
    output logic [SIZE-1:0]        div_divisor,
    input  logic [SIZE-1:0]        div_quotient,
    input  logic [SIZE-1:0]        div_remainder,
    input  logic                   div_zeroflag,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [SIZE-1:0]        rsp_quotient,
    output logic [SIZE-1:0]        rsp_remainder,
    output logic                   rsp_divzero
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a requester holds valid and operands until it sees ready.
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t          state, state_nxt;
    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  grant;
    logic            grant_found;
    logic [IDW-1:0]  cur_id;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] sel_dividend;
    logic [SIZE-1:0] sel_divisor;
    logic            accept;

    // First valid requester after last_grant, wrapping modulo NREQ.
    always_comb begin : grant_scan
        int idx;
        idx         = 0;
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!grant_found && req_valid[IDW'(idx)]) begin
                grant       = IDW'(idx);
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_dividend = req_dividend[i*SIZE +: SIZE];
                sel_divisor  = req_divisor[i*SIZE +: SIZE];
            end
        end
    end

    // rst_n gates ready so nothing is offered while reset is held.
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && rst_n && grant_found)
            req_ready[grant] = 1'b1;
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_SETTLE;
            S_SETTLE: if (cnt == '0) state_nxt = S_RESP;
            S_RESP:   if (rsp_valid && rsp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant    <= IDW'(NREQ - 1);
            cur_id        <= '0;
            cnt           <= '0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_divzero   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        cur_id       <= grant;
                        last_grant   <= grant;
                        cnt          <= CW'(SETTLE - 1);
                    end
                end
                S_SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // Divide by zero returns all-ones quotient and the dividend as remainder.
                        rsp_valid     <= 1'b1;
                        rsp_id        <= cur_id;
                        rsp_quotient  <= div_zeroflag ? {SIZE{1'b1}} : div_quotient;
                        rsp_remainder <= div_zeroflag ? div_dividend : div_remainder;
                        rsp_divzero   <= div_zeroflag;
                    end
                end
                S_RESP: begin
                    if (rsp_valid && rsp_ready)
                        rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divide_arbiter.sv
// Randomised and directed bench for divide_arbiter with a behavioural divider and
// a scoreboard of expected responses.
module tb_divide_arbiter;
  localparam int SIZE = 16;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  localparam int SETTLE = 3;
  localparam int EW = IDW + 2 * SIZE + 1;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*SIZE-1:0] req_dividend;
  logic [NREQ*SIZE-1:0] req_divisor;
  logic [SIZE-1:0]      div_dividend;
  logic [SIZE-1:0]      div_divisor;
  logic [SIZE-1:0]      div_quotient;
  logic [SIZE-1:0]      div_remainder;
  logic                 div_zeroflag;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [SIZE-1:0]      rsp_quotient;
  logic [SIZE-1:0]      rsp_remainder;
  logic                 rsp_divzero;

  divide_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .IDW(IDW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_zeroflag(div_zeroflag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_divzero(rsp_divzero)
  );

  // Shared divider; on a zero divisor it returns junk the block must override.
  assign div_zeroflag  = (div_divisor == '0);
  assign div_quotient  = div_zeroflag ? 16'h5A5A : div_dividend / div_divisor;
  assign div_remainder = div_zeroflag ? 16'hA5A5 : div_dividend % div_divisor;

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rr_mode = 0;
  int acc_req = -1;
  logic [EW-1:0] exp_q[$];
  logic [2*SIZE-1:0] jobs[NREQ][$];
  logic [IDW-1:0] m_last;
  bit m_busy;
  int m_due;
  logic [SIZE-1:0] m_a, m_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2*SIZE:0] ref_div(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    if (b == 0) return {{SIZE{1'b1}}, a, 1'b1};
    return {a / b, a % b, 1'b0};
  endfunction

  task automatic set_ops(input int i, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    req_dividend[i*SIZE +: SIZE] = a;
    req_divisor[i*SIZE +: SIZE]  = b;
  endtask

  task automatic add_job(input int i, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    jobs[i].push_back({a, b});
  endtask

  // monitor: compares the head of the queue whenever a response is shown, pops on handshake
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      else begin
        check("rsp_word", 64'({rsp_id, rsp_quotient, rsp_remainder, rsp_divzero}), 64'(exp_q[0]));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // driver + reference model for one clock cycle
  task automatic cycle_step();
    logic [NREQ-1:0] exp_ready;
    logic [2*SIZE-1:0] job;
    int g;
    int idx;
    @(posedge clk); #1;
    cyc++;
    if (acc_req >= 0) begin
      req_valid[acc_req] = 1'b0;
      set_ops(acc_req, SIZE'($urandom), SIZE'($urandom));
      acc_req = -1;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!req_valid[i] && jobs[i].size() > 0) begin
        job = jobs[i].pop_front();
        set_ops(i, job[2*SIZE-1:SIZE], job[SIZE-1:0]);
        req_valid[i] = 1'b1;
      end
    end
    rsp_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    @(negedge clk);
    g = -1;
    exp_ready = '0;
    if (!m_busy) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (int'(m_last) + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("rsp_valid_timing", 64'(rsp_valid), 64'(m_busy && cyc >= m_due));
    if (m_busy) check("div_operands", 64'({div_dividend, div_divisor}), 64'({m_a, m_b}));
    if (g >= 0) begin
      acc_req = g;
      m_last = IDW'(g);
      m_busy = 1'b1;
      m_due = cyc + SETTLE + 1;
      m_a = req_dividend[g*SIZE +: SIZE];
      m_b = req_divisor[g*SIZE +: SIZE];
      exp_q.push_back({IDW'(g), ref_div(m_a, m_b)});
    end else if (m_busy && cyc >= m_due && rsp_ready) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle_step();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_fields", 64'({rsp_id, rsp_quotient, rsp_remainder, rsp_divzero}), 64'd0);
    check("rst_div_ops", 64'({div_dividend, div_divisor}), 64'd0);
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) jobs[i].delete();
    exp_q.delete();
    m_busy = 1'b0;
    m_last = IDW'(NREQ - 1);
    acc_req = -1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    logic [SIZE-1:0] ra, rb;
    rst_n = 1'b1;
    req_valid = '1;
    req_dividend = '0;
    req_divisor = '0;
    rsp_ready = 1'b1;
    m_last = IDW'(NREQ - 1);
    m_busy = 1'b0;
    m_due = 0;
    m_a = '0;
    m_b = '0;
    do_reset();

    add_job(1, 16'd100, 16'd7);
    run(8);
    add_job(2, 16'h04D2, 16'd0);
    run(8);

    do_reset();
    add_job(0, 16'd1000, 16'd3);
    add_job(1, 16'd4321, 16'd10);
    add_job(2, 16'd77, 16'd77);
    add_job(3, 16'd65000, 16'd255);
    add_job(0, 16'd9, 16'd2);
    run(30);

    rr_mode = 1;
    add_job(0, 16'd500, 16'd6);
    run(2);
    add_job(3, 16'd12345, 16'd100);
    run(10);
    rr_mode = 0;
    run(12);

    add_job(1, 16'd999, 16'd4);
    run(3);
    do_reset();
    add_job(2, 16'd60, 16'd7);
    add_job(0, 16'd61, 16'd8);
    run(16);

    add_job(0, 16'hFFFF, 16'd1);
    add_job(1, 16'd5, 16'd9);
    add_job(2, 16'd0, 16'd3);
    run(22);

    rr_mode = 2;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, NREQ - 1);
      ra = SIZE'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 :
           ($urandom_range(0, 1) == 0) ? SIZE'($urandom_range(1, 20)) : SIZE'($urandom);
      if ($urandom_range(0, 2) == 0 && jobs[r].size() < 2) add_job(r, ra, rb);
      cycle_step();
    end
    rr_mode = 0;
    run(60);
    check("drain_queue", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
